// File: rtl/timer_bcd_counter.sv
// timer_bcd_counter
//   Turns each rising edge of timer_clk (a level synchronous to sys_clk) into
//   a one-second tick and keeps an MM:SS count in packed BCD. Counts up with
//   wrap at MIN_LIMIT:59 or down with expiry at 00:00. Accepts a validated
//   BCD preload.
//
// Ports
//   sys_clk      in   system clock
//   int_reset_b  in   asynchronous active-low reset
//   timer_clk    in   divided timer level; rising edge = one tick
//   timer_clear  in   synchronous clear of count, done and pulses
//   timer_pause  in   hold count; ticks during pause are dropped
//   count_down   in   1 = count down, 0 = count up (sampled on a tick)
//   load         in   single-cycle preload strobe
//   load_bcd     in   [15:12] min tens, [11:8] min ones, [7:4] sec tens, [3:0] sec ones
//   time_bcd     out  current count, same packing as load_bcd
//   timer_done   out  sticky, high while the FSM is EXPIRED (FSM state view)
//   rollover     out  one-cycle pulse on the up-mode wrap to 00:00
//   load_err     out  one-cycle pulse when a load is rejected
//
// Handshake: there is none; load and timer_clear are single-cycle strobes
// acted on in the cycle they are high, with priority
// timer_clear > load > timer_pause > tick.
module timer_bcd_counter #(
    parameter int unsigned MIN_LIMIT = 59
) (
    input  logic        sys_clk,
    input  logic        int_reset_b,
    input  logic        timer_clk,
    input  logic        timer_clear,
    input  logic        timer_pause,
    input  logic        count_down,
    input  logic        load,
    input  logic [15:0] load_bcd,
    output logic [15:0] time_bcd,
    output logic        timer_done,
    output logic        rollover,
    output logic        load_err
);

    typedef enum logic {RUN = 1'b0, EXPIRED = 1'b1} state_e;

    localparam logic [7:0] MIN_LIMIT_L = 8'(MIN_LIMIT);

    state_e      state_q;
    logic [15:0] time_q;
    logic        timer_clk_q;
    logic        done_q;
    logic        rollover_q;
    logic        load_err_q;

    logic        tick;
    logic [3:0]  s1, s10, m1, m10;
    logic [7:0]  min_val;
    logic [15:0] up_d;
    logic        up_wrap;
    logic [15:0] down_d;
    logic        at_zero;
    logic [7:0]  ld_min;
    logic        load_valid;

    assign tick = timer_clk & ~timer_clk_q;

    assign s1  = time_q[3:0];
    assign s10 = time_q[7:4];
    assign m1  = time_q[11:8];
    assign m10 = time_q[15:12];

    assign min_val = {4'd0, m10} * 8'd10 + {4'd0, m1};
    assign at_zero = (time_q == 16'h0000);

    // Up-count ripple; the wrap decision uses the minute value so any
    // MIN_LIMIT (not only 59/99) wraps at the right place.
    always_comb begin
        up_d    = time_q;
        up_wrap = 1'b0;
        if (s1 != 4'd9) begin
            up_d[3:0] = s1 + 4'd1;
        end else begin
            up_d[3:0] = 4'd0;
            if (s10 != 4'd5) begin
                up_d[7:4] = s10 + 4'd1;
            end else begin
                up_d[7:4] = 4'd0;
                if (min_val >= MIN_LIMIT_L) begin
                    up_d    = 16'h0000;
                    up_wrap = 1'b1;
                end else if (m1 != 4'd9) begin
                    up_d[11:8] = m1 + 4'd1;
                end else begin
                    up_d[11:8]  = 4'd0;
                    up_d[15:12] = m10 + 4'd1;
                end
            end
        end
    end

    // Down-count ripple borrow; only used when the count is non-zero.
    always_comb begin
        down_d = time_q;
        if (s1 != 4'd0) begin
            down_d[3:0] = s1 - 4'd1;
        end else begin
            down_d[3:0] = 4'd9;
            if (s10 != 4'd0) begin
                down_d[7:4] = s10 - 4'd1;
            end else begin
                down_d[7:4] = 4'd5;
                if (m1 != 4'd0) begin
                    down_d[11:8] = m1 - 4'd1;
                end else begin
                    down_d[11:8]  = 4'd9;
                    down_d[15:12] = m10 - 4'd1;
                end
            end
        end
    end

    // Preload validation; minute value is 8 bits because illegal digits
    // (up to 15) can push 10*tens+ones past 127.
    assign ld_min = {4'd0, load_bcd[15:12]} * 8'd10 + {4'd0, load_bcd[11:8]};
    assign load_valid = (load_bcd[3:0]   <= 4'd9) &&
                        (load_bcd[7:4]   <= 4'd5) &&
                        (load_bcd[11:8]  <= 4'd9) &&
                        (load_bcd[15:12] <= 4'd9) &&
                        (ld_min <= MIN_LIMIT_L);

    always_ff @(posedge sys_clk or negedge int_reset_b) begin
        if (!int_reset_b) begin
            state_q     <= RUN;
            time_q      <= 16'h0000;
            timer_clk_q <= 1'b0;
            done_q      <= 1'b0;
            rollover_q  <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            // Edge detector tracks every cycle, so ticks seen during pause,
            // clear or load are lost rather than replayed.
            timer_clk_q <= timer_clk;
            rollover_q  <= 1'b0;
            load_err_q  <= 1'b0;
            if (timer_clear) begin
                time_q  <= 16'h0000;
                state_q <= RUN;
                done_q  <= 1'b0;
            end else if (load) begin
                if (load_valid) begin
                    time_q  <= load_bcd;
                    state_q <= RUN;
                    done_q  <= 1'b0;
                end else begin
                    load_err_q <= 1'b1;
                end
            end else if (!timer_pause && tick && state_q == RUN) begin
                if (count_down) begin
                    if (at_zero) begin
                        // Already at 00:00 (e.g. after loading 0000): expire
                        // without touching the count.
                        state_q <= EXPIRED;
                        done_q  <= 1'b1;
                    end else begin
                        time_q <= down_d;
                        if (down_d == 16'h0000) begin
                            state_q <= EXPIRED;
                            done_q  <= 1'b1;
                        end
                    end
                end else begin
                    time_q     <= up_d;
                    rollover_q <= up_wrap;
                end
            end
        end
    end

    assign time_bcd   = time_q;
    assign timer_done = done_q;
    assign rollover   = rollover_q;
    assign load_err   = load_err_q;

endmodule

// File: tb/tb_timer_bcd_counter.sv
// Bench for timer_bcd_counter. The expected count comes from an integer
// seconds model (total seconds, converted to BCD), not from a digit ripple.
// Inputs change on the falling edge of sys_clk, outputs are sampled on the
// falling edge (or 1 ns after it for the pre-edge hold check).
module tb_timer_bcd_counter;

  localparam int MIN_LIMIT = 59;
  localparam int WRAP      = (MIN_LIMIT + 1) * 60;

  logic        sys_clk;
  logic        int_reset_b;
  logic        timer_clk;
  logic        timer_clear;
  logic        timer_pause;
  logic        count_down;
  logic        load;
  logic [15:0] load_bcd;
  logic [15:0] time_bcd;
  logic        timer_done;
  logic        rollover;
  logic        load_err;

  timer_bcd_counter #(.MIN_LIMIT(MIN_LIMIT)) dut (
    .sys_clk     (sys_clk),
    .int_reset_b (int_reset_b),
    .timer_clk   (timer_clk),
    .timer_clear (timer_clear),
    .timer_pause (timer_pause),
    .count_down  (count_down),
    .load        (load),
    .load_bcd    (load_bcd),
    .time_bcd    (time_bcd),
    .timer_done  (timer_done),
    .rollover    (rollover),
    .load_err    (load_err)
  );

  // ---------------- clock / reset ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int model_total = 0;
  logic model_done = 1'b0;
  logic [17:0] exp_q[$];   // {rollover, done, bcd}

  typedef struct {
    logic [15:0] load_val;
    logic        down;
    int          n_ticks;
    logic [15:0] exp_bcd;
    logic        exp_done;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [15:0] to_bcd(input int total);
    int m, s;
    m = total / 60;
    s = total % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- driver tasks (start and end on a falling edge) ----------------
  task automatic do_tick(input logic down);
    logic [15:0] before_bcd;
    logic        roll;
    logic [17:0] e;
    before_bcd = to_bcd(model_total);
    roll = 1'b0;
    if (!model_done) begin
      if (down) begin
        if (model_total == 0) model_done = 1'b1;
        else begin
          model_total--;
          if (model_total == 0) model_done = 1'b1;
        end
      end else begin
        if (model_total == WRAP - 1) begin
          model_total = 0;
          roll = 1'b1;
        end else model_total++;
      end
    end
    exp_q.push_back({roll, model_done, to_bcd(model_total)});
    count_down = down;
    timer_clk  = 1'b1;
    #1 check("pre_edge_hold", 32'(time_bcd), 32'(before_bcd));
    @(negedge sys_clk);
    e = exp_q.pop_front();
    check("tick_bcd", 32'(time_bcd), 32'(e[15:0]));
    check("tick_done", 32'(timer_done), 32'(e[16]));
    check("tick_rollover", 32'(rollover), 32'(e[17]));
    timer_clk = 1'b0;
    @(negedge sys_clk);
    check("rollover_one_cycle", 32'(rollover), 32'd0);
  endtask

  task automatic do_load(input logic [15:0] v);
    int  m;
    logic ok;
    m  = int'(v[15:12]) * 10 + int'(v[11:8]);
    ok = (v[3:0] <= 9) && (v[7:4] <= 5) && (v[11:8] <= 9) && (v[15:12] <= 9) && (m <= MIN_LIMIT);
    if (ok) begin
      model_total = m * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
      model_done  = 1'b0;
    end
    load     = 1'b1;
    load_bcd = v;
    @(negedge sys_clk);
    load = 1'b0;
    check("load_bcd", 32'(time_bcd), 32'(to_bcd(model_total)));
    check("load_err", 32'(load_err), 32'(!ok));
    check("load_done", 32'(timer_done), 32'(model_done));
    @(negedge sys_clk);
    check("load_err_one_cycle", 32'(load_err), 32'd0);
  endtask

  task automatic do_clear();
    timer_clear = 1'b1;
    @(negedge sys_clk);
    timer_clear = 1'b0;
    model_total = 0;
    model_done  = 1'b0;
    check("clear_bcd", 32'(time_bcd), 32'h0);
    check("clear_done", 32'(timer_done), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{16'h0000, 1'b0, 60, 16'h0100, 1'b0};
    vecs[1] = '{16'h5959, 1'b0,  1, 16'h0000, 1'b0};
    vecs[2] = '{16'h0100, 1'b1,  1, 16'h0059, 1'b0};
    vecs[3] = '{16'h0002, 1'b1,  2, 16'h0000, 1'b1};
    vecs[4] = '{16'h0959, 1'b0,  1, 16'h1000, 1'b0};
    vecs[5] = '{16'h1000, 1'b1,  1, 16'h0959, 1'b0};
    vecs[6] = '{16'h0000, 1'b1,  1, 16'h0000, 1'b1};
    vecs[7] = '{16'h4509, 1'b0,  3, 16'h4512, 1'b0};
    vecs[8] = '{16'h3000, 1'b1, 61, 16'h2859, 1'b0};

    int_reset_b = 1'b0;
    timer_clk   = 1'b0;
    timer_clear = 1'b0;
    timer_pause = 1'b0;
    count_down  = 1'b0;
    load        = 1'b0;
    load_bcd    = 16'h0000;
    repeat (2) @(negedge sys_clk);
    check("reset_bcd", 32'(time_bcd), 32'h0);
    check("reset_done", 32'(timer_done), 32'd0);
    check("reset_rollover", 32'(rollover), 32'd0);
    check("reset_load_err", 32'(load_err), 32'd0);
    int_reset_b = 1'b1;
    @(negedge sys_clk);

    // Up count straight out of reset, no preload.
    for (int i = 0; i < 5; i++) do_tick(1'b0);
    check("post_reset_up", 32'(time_bcd), 32'h0005);

    // Table-driven vectors.
    for (int i = 0; i < 9; i++) begin
      do_load(vecs[i].load_val);
      for (int t = 0; t < vecs[i].n_ticks; t++) do_tick(vecs[i].down);
      check($sformatf("vec%0d_bcd", i), 32'(time_bcd), 32'(vecs[i].exp_bcd));
      check($sformatf("vec%0d_done", i), 32'(timer_done), 32'(vecs[i].exp_done));
    end

    // Expiry is sticky: further ticks change nothing, clear drops done.
    do_load(16'h0002);
    do_tick(1'b1);
    do_tick(1'b1);
    check("expired_done", 32'(timer_done), 32'd1);
    do_tick(1'b1);
    do_tick(1'b0);
    check("expired_hold_bcd", 32'(time_bcd), 32'h0);
    check("expired_hold_done", 32'(timer_done), 32'd1);
    do_clear();

    // Valid load leaves EXPIRED and counting resumes.
    do_tick(1'b1);
    check("expire_from_zero", 32'(timer_done), 32'd1);
    do_load(16'h0005);
    do_tick(1'b1);
    check("load_exits_expired", 32'(time_bcd), 32'h0004);

    // Rejected loads leave the count alone.
    do_load(16'h0060);
    do_load(16'h6000);
    do_load(16'h000A);
    do_load(16'hA000);
    check("rejected_keep", 32'(time_bcd), 32'h0004);

    // Direction switch takes effect on the next tick.
    do_load(16'h0010);
    do_tick(1'b0);
    do_tick(1'b1);
    do_tick(1'b1);
    check("dir_switch", 32'(time_bcd), 32'h0009);

    // Clear + load + tick in one cycle: clear wins, no pulses.
    do_load(16'h1234);
    timer_clear = 1'b1;
    load        = 1'b1;
    load_bcd    = 16'h0500;
    timer_clk   = 1'b1;
    @(negedge sys_clk);
    timer_clear = 1'b0;
    load        = 1'b0;
    model_total = 0;
    model_done  = 1'b0;
    check("clr_ld_tick_bcd", 32'(time_bcd), 32'h0);
    check("clr_ld_tick_roll", 32'(rollover), 32'd0);
    check("clr_ld_tick_err", 32'(load_err), 32'd0);
    check("clr_ld_tick_done", 32'(timer_done), 32'd0);
    timer_clk = 1'b0;
    @(negedge sys_clk);

    // Load + tick: load wins, tick dropped.
    load      = 1'b1;
    load_bcd  = 16'h0300;
    timer_clk = 1'b1;
    count_down = 1'b0;
    @(negedge sys_clk);
    load = 1'b0;
    model_total = 180;
    check("load_tick_bcd", 32'(time_bcd), 32'h0300);
    timer_clk = 1'b0;
    @(negedge sys_clk);

    // Pause across three ticks, then release: one tick advances by one.
    timer_pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      timer_clk = 1'b1;
      @(negedge sys_clk);
      timer_clk = 1'b0;
      @(negedge sys_clk);
    end
    do_load(16'h0310);   // load is honoured while paused
    check("pause_hold", 32'(time_bcd), 32'h0310);
    timer_pause = 1'b0;
    @(negedge sys_clk);
    check("pause_no_replay", 32'(time_bcd), 32'h0310);
    do_tick(1'b0);
    check("pause_release_step", 32'(time_bcd), 32'h0311);

    // Random walk against the model.
    for (int i = 0; i < 40; i++) do_tick(1'($urandom_range(0, 1)));

    // Asynchronous reset mid-count.
    do_load(16'h2222);
    #3 int_reset_b = 1'b0;
    #1 check("async_reset_bcd", 32'(time_bcd), 32'h0);
    check("async_reset_done", 32'(timer_done), 32'd0);
    @(negedge sys_clk);
    int_reset_b = 1'b1;
    model_total = 0;
    model_done  = 1'b0;
    @(negedge sys_clk);
    do_tick(1'b0);
    check("after_reset_tick", 32'(time_bcd), 32'h0001);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
